// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO so the host can queue bytes.
// Ports: osc_clk, i_Rst (sync, high), i_Tx_DV/i_Tx_Byte in; o_Tx_Ready,
//   o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Empty out (all registered).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1181,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       osc_clk,
  input  logic       i_Rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Tx_Empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   CNT_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic [7:0]  shift;

  logic push;
  logic pop;
  logic bit_end;
  logic not_empty;
  logic line_nxt;
  logic empty_nxt;

  assign push      = i_Tx_DV && o_Tx_Ready;
  assign not_empty = (count != '0);
  assign bit_end   = (cnt == CNT_LAST);

  // A byte leaves the FIFO either from idle or on the last stop-bit
  // cycle, so the next frame starts with no idle gap.
  assign pop = not_empty &&
               ((state == S_IDLE) ||
                ((state == S_STOP) && bit_end));

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (pop) state_nxt = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == 3'd7) begin
            idx_nxt   = '0;
            state_nxt = S_STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = not_empty ? S_START : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Line level follows the current state; registering it keeps the
  // output glitch-free and delays every bit by exactly one cycle.
  always_comb begin
    line_nxt = 1'b1;
    case (state)
      S_START: line_nxt = 1'b0;
      S_DATA:  line_nxt = shift[idx];
      default: line_nxt = 1'b1;
    endcase
  end

  // Empty only once the stop bit has fully left the line.
  assign empty_nxt = (state == S_IDLE) &&
                     (state_nxt == S_IDLE) &&
                     (count_nxt == '0);

  always_ff @(posedge osc_clk) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  always_ff @(posedge osc_clk) begin
    if (i_Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_Tx_Ready  <= 1'b1;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
      o_Tx_Empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shift  <= mem[rd_ptr];
      end
      count       <= count_nxt;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      o_Tx_Ready  <= (count_nxt < DEPTH_C);
      o_Tx_Serial <= line_nxt;
      o_Tx_Active <= (state != S_IDLE);
      o_Tx_Done   <= (state == S_STOP) && bit_end;
      o_Tx_Empty  <= empty_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Outputs are logged every falling edge and frames decoded from the log.
module tb_uart_tx_fifo;

  localparam int CPB  = 8;
  localparam int LOGN = 16384;

  logic       osc_clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Tx_DV = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Tx_Ready;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;
  logic       o_Tx_Empty;

  int checks = 0;
  int failures = 0;

  logic lser [LOGN];
  logic lact [LOGN];
  logic ldone [LOGN];
  logic lemp [LOGN];
  int   cyc = 0;

  logic [7:0] q [$];

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .osc_clk(osc_clk),
    .i_Rst(i_Rst),
    .i_Tx_DV(i_Tx_DV),
    .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Ready(o_Tx_Ready),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Done(o_Tx_Done),
    .o_Tx_Empty(o_Tx_Empty)
  );

  always #5 osc_clk = ~osc_clk;

  always @(negedge osc_clk) begin
    if (cyc < LOGN) begin
      lser[cyc]  <= o_Tx_Serial;
      lact[cyc]  <= o_Tx_Active;
      ldone[cyc] <= o_Tx_Done;
      lemp[cyc]  <= o_Tx_Empty;
    end
    cyc <= cyc + 1;
  end

  function automatic int find_fall(input int from, input int to);
    for (int i = from; i < to && i < LOGN; i++)
      if (lser[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [7:0] dec(input int s);
    logic [7:0] d;
    d = 8'h00;
    for (int b = 0; b < 8; b++) d[b] = lser[s + CPB*(b+1) + 4];
    return d;
  endfunction

  function automatic int cnt_done(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i < to && i < LOGN; i++)
      if (ldone[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic push_q(output int ts);
    ts = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge osc_clk);
      if (i == 0) ts = cyc;
      i_Tx_DV   = 1'b1;
      i_Tx_Byte = q[i];
    end
    @(negedge osc_clk);
    i_Tx_DV   = 1'b0;
    i_Tx_Byte = 8'h00;
  endtask

  task automatic idle_wait(input string name);
    int n;
    n = 0;
    while (!(o_Tx_Empty === 1'b1 && o_Tx_Active === 1'b0) && n < 3000) begin
      @(negedge osc_clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s idle_timeout got=%0d cycles need<3000", name, n);
    end
    repeat (4) @(negedge osc_clk);
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (3) @(negedge osc_clk);
    i_Rst = 1'b0;
    @(negedge osc_clk);
    checks++;
    if (o_Tx_Serial !== 1'b1) begin
      failures++; $display("FAIL reset_serial got=%b need=1", o_Tx_Serial);
    end
    checks++;
    if (o_Tx_Ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b need=1", o_Tx_Ready);
    end
    checks++;
    if (o_Tx_Active !== 1'b0) begin
      failures++; $display("FAIL reset_active got=%b need=0", o_Tx_Active);
    end
    checks++;
    if (o_Tx_Done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b need=0", o_Tx_Done);
    end
    checks++;
    if (o_Tx_Empty !== 1'b1) begin
      failures++; $display("FAIL reset_empty got=%b need=1", o_Tx_Empty);
    end
  endtask

  task automatic test_single();
    int ts, t0;
    logic [9:0] fr;
    logic bad;
    fr = {1'b1, 8'hA5, 1'b0};
    @(negedge osc_clk);
    ts = cyc;
    i_Tx_DV = 1'b1;
    i_Tx_Byte = 8'hA5;
    @(negedge osc_clk);
    i_Tx_DV = 1'b0;
    i_Tx_Byte = 8'h00;
    repeat (100) @(negedge osc_clk);
    t0 = find_fall(ts, ts + 100);
    checks++;
    if (t0 != ts + 3) begin
      failures++; $display("FAIL single_latency got=%0d need=%0d", t0 - ts, 3);
    end
    for (int j = 0; j < 10; j++) begin
      bad = 1'b0;
      for (int c = 0; c < CPB; c++)
        if (lser[ts + 3 + CPB*j + c] !== fr[j]) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++; $display("FAIL single_bit%0d got=wrong_level need=%b", j, fr[j]);
      end
    end
    checks++;
    if (cnt_done(ts, ts + 100) != 1 || ldone[ts + 82] !== 1'b1) begin
      failures++;
      $display("FAIL single_done got=%0d pulses,at80=%b need=1,1",
               cnt_done(ts, ts + 100), ldone[ts + 82]);
    end
    checks++;
    if (lact[ts + 3] !== 1'b1 || lact[ts + 82] !== 1'b1 || lact[ts + 83] !== 1'b0) begin
      failures++;
      $display("FAIL single_active got=%b%b%b need=110",
               lact[ts + 3], lact[ts + 82], lact[ts + 83]);
    end
    checks++;
    if (lemp[ts + 82] !== 1'b0 || lemp[ts + 83] !== 1'b1) begin
      failures++;
      $display("FAIL single_empty got=%b%b need=01", lemp[ts + 82], lemp[ts + 83]);
    end
  endtask

  task automatic test_back_to_back();
    int ts, t0;
    logic bad;
    q = '{8'h01, 8'h02, 8'h03};
    push_q(ts);
    repeat (300) @(negedge osc_clk);
    t0 = find_fall(ts, ts + 300);
    checks++;
    if (t0 != ts + 3) begin
      failures++; $display("FAIL b2b_start got=%0d need=%0d", t0 - ts, 3);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (dec(t0 + 80*j) !== 8'(j + 1)) begin
        failures++;
        $display("FAIL b2b_byte%0d got=%h need=%h", j, dec(t0 + 80*j), 8'(j + 1));
      end
    end
    bad = 1'b0;
    for (int i = 0; i < 240; i++) if (lact[t0 + i] !== 1'b1) bad = 1'b1;
    checks++;
    if (bad || lact[t0 + 240] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_active got=gap%b,end%b need=gap0,end0", bad, lact[t0 + 240]);
    end
    checks++;
    if (cnt_done(ts, ts + 300) != 3 || ldone[t0 + 79] !== 1'b1 ||
        ldone[t0 + 159] !== 1'b1 || ldone[t0 + 239] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got=%0d pulses need=3 at 80/160/240",
               cnt_done(ts, ts + 300));
    end
  endtask

  task automatic test_overflow();
    int ts, t0;
    logic [5:0] rdy;
    logic [7:0] bytes [6];
    bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    ts = 0;
    rdy = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge osc_clk);
      if (i == 0) ts = cyc;
      rdy[i] = o_Tx_Ready;
      i_Tx_DV = 1'b1;
      i_Tx_Byte = bytes[i];
    end
    @(negedge osc_clk);
    i_Tx_DV = 1'b0;
    i_Tx_Byte = 8'h00;
    checks++;
    if (rdy !== 6'b011111) begin
      failures++; $display("FAIL ovf_ready got=%b need=011111", rdy);
    end
    repeat (500) @(negedge osc_clk);
    t0 = find_fall(ts, ts + 500);
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (dec(t0 + 80*j) !== bytes[j]) begin
        failures++;
        $display("FAIL ovf_byte%0d got=%h need=%h", j, dec(t0 + 80*j), bytes[j]);
      end
    end
    checks++;
    if (find_fall(t0 + 400, t0 + 490) != -1) begin
      failures++; $display("FAIL ovf_extra_frame got=sixth_frame need=none");
    end
    checks++;
    if (cnt_done(ts, t0 + 490) != 5) begin
      failures++; $display("FAIL ovf_done got=%0d need=5", cnt_done(ts, t0 + 490));
    end
    checks++;
    if (lemp[t0 + 399] !== 1'b0 || lemp[t0 + 400] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_empty got=%b%b need=01", lemp[t0 + 399], lemp[t0 + 400]);
    end
  endtask

  task automatic test_reset_mid();
    int ts;
    q = '{8'h0F, 8'h33, 8'h44};
    push_q(ts);
    repeat (33) @(negedge osc_clk);
    i_Rst = 1'b1;
    @(negedge osc_clk);
    i_Rst = 1'b0;
    checks++;
    if (lact[ts + 36] !== 1'b1) begin
      failures++; $display("FAIL rstmid_inflight got=%b need=1", lact[ts + 36]);
    end
    checks++;
    if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_line got=%b/%b need=1/0", o_Tx_Serial, o_Tx_Active);
    end
    checks++;
    if (o_Tx_Ready !== 1'b1 || o_Tx_Empty !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_flags got=%b/%b need=1/1", o_Tx_Ready, o_Tx_Empty);
    end
    repeat (200) @(negedge osc_clk);
    checks++;
    if (find_fall(ts + 37, ts + 237) != -1 || o_Tx_Empty !== 1'b1) begin
      failures++; $display("FAIL rstmid_flush got=frame_after_reset need=none");
    end
  endtask

  task automatic test_stream();
    int ts, t0;
    logic [7:0] bytes [5];
    bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h80};
    q = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h80};
    push_q(ts);
    repeat (450) @(negedge osc_clk);
    t0 = find_fall(ts, ts + 450);
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (dec(t0 + 80*j) !== bytes[j] || lser[t0 + 80*j + 76] !== 1'b1) begin
        failures++;
        $display("FAIL stream_byte%0d got=%h stop=%b need=%h stop=1",
                 j, dec(t0 + 80*j), lser[t0 + 80*j + 76], bytes[j]);
      end
    end
  endtask

  task automatic test_full_refill();
    int ts, t0, n, seen;
    logic [7:0] bytes [6];
    bytes = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    push_q(ts);
    checks++;
    if (o_Tx_Ready !== 1'b0) begin
      failures++; $display("FAIL full_ready got=%b need=0", o_Tx_Ready);
    end
    i_Tx_DV = 1'b1;
    i_Tx_Byte = 8'h66;
    n = 0;
    seen = -1;
    while (n < 300) begin
      @(negedge osc_clk);
      n++;
      if (o_Tx_Ready === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    @(negedge osc_clk);
    i_Tx_DV = 1'b0;
    i_Tx_Byte = 8'h00;
    checks++;
    if (seen != ts + 82) begin
      failures++; $display("FAIL full_reopen got=%0d need=%0d", seen - ts, 82);
    end
    checks++;
    if (o_Tx_Ready !== 1'b0) begin
      failures++; $display("FAIL full_refilled got=%b need=0", o_Tx_Ready);
    end
    repeat (600) @(negedge osc_clk);
    t0 = find_fall(ts, ts + 600);
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (dec(t0 + 80*j) !== bytes[j]) begin
        failures++;
        $display("FAIL full_byte%0d got=%h need=%h", j, dec(t0 + 80*j), bytes[j]);
      end
    end
    checks++;
    if (find_fall(t0 + 480, t0 + 570) != -1) begin
      failures++; $display("FAIL full_dup got=seventh_frame need=none");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    idle_wait("single");
    test_back_to_back();
    idle_wait("b2b");
    test_overflow();
    idle_wait("ovf");
    test_reset_mid();
    idle_wait("rstmid");
    test_stream();
    idle_wait("stream");
    test_full_refill();
    idle_wait("full");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
